sr_flop_bank: RTL and testbench
===============================

# sr_flop_bank

Parametrised bank of WIDTH clocked SR flip-flops sharing one clock, enable and reset. It is the successor to the single-bit clocked SR latch. Its additions are:
- a configurable policy for the forbidden S=R=1 input;
- per-channel conflict and change reporting;
- a sticky error flag with a saturating conflict counter.

It sits wherever the design needs many set/reset status bits, such as interrupt pending bits or mode flags.

## Interface
- WIDTH, 8, number of independent SR channels (1..64)
- INIT, {WIDTH{1'b0}}, value loaded into q on reset
- POLICY, 0, response to s=r=1: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle (JK behaviour)
- CNT_W, 8, width of err_cnt (2..16)

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- en  in  1  clock enable; when 0, all channel state holds
- s  in  WIDTH  per-channel set request
- r  in  WIDTH  per-channel reset request
- clr_err  in  1  synchronous clear of err_sticky and err_cnt; not gated by en
- q  out  WIDTH  channel state
- qb  out  WIDTH  always ~q
- conflict  out  WIDTH  registered; bit i = 1 if s[i]&r[i] was sampled with en=1 on the last edge
- changed  out  WIDTH  registered; bit i = 1 if q[i] changed on the last edge
- err_sticky  out  1  set by any conflict; cleared only by clr_err or reset
- err_cnt  out  CNT_W  saturating count of enabled edges with at least one conflicting channel

## Operation
- Per channel, with en=1 at the edge:
  - s=0, r=0: hold
  - s=1, r=0: q=1
  - s=0, r=1: q=0
  - s=1, r=1: apply POLICY
- POLICY is elaboration-time only. Any illegal value is a compile-time error.
- qb is the bitwise inverse of the q register. q and qb are never equal, which removes the latch's invalid q=qb state.
- conflict[i] = en & s[i] & r[i], registered. It is reported regardless of POLICY, including under toggle.
- changed[i] = q_next[i] ^ q[i], registered. It is 0 on every edge where en=0.
- Error tracking happens on each edge:
  - any_conflict = en & |(s&r)
  - If clr_err=1: err_cnt becomes any_conflict (0 or 1), and err_sticky becomes any_conflict.
  - Otherwise, if any_conflict=1: err_sticky=1 and err_cnt increments, saturating at 2^CNT_W-1.
- err_cnt counts edges, not channels. Three conflicting channels in one cycle add 1.
- en=0: q, conflict and changed do not evaluate s and r. conflict and changed go to 0. The error logic still honours clr_err.

## Timing
- Async reset assertion applies immediately, independent of clk:
  - q=INIT and qb=~INIT
  - conflict=0 and changed=0
  - err_sticky=0 and err_cnt=0
- Release of rst_n is synchronised by the integrator. The first edge after release is a normal edge.
- Latency: inputs sampled at edge N are reflected on every output after edge N. There is one cycle of latency and no combinational input-to-output path.
- Reset asserted mid-operation discards any pending update. An edge coincident with rst_n low is ignored.
- Saturation boundary:
  - At err_cnt=2^CNT_W-1 with a further conflict, the count stays at max and err_sticky stays 1.
  - clr_err on that same edge yields err_cnt=1.
- Toggle policy with s=r=1 held for several enabled edges: q alternates every edge, changed=1 every edge, and err_cnt increments every edge.

## Test plan
- Reset with WIDTH=8, INIT=8'hA5: assert rst_n=0 with no clk edge -> q=8'hA5, qb=8'h5A, err_cnt=0, and all flags 0.
- POLICY=0, INIT=0, en=1:
  - s=8'h0F, r=0 -> after the edge, q=8'h0F and changed=8'h0F.
  - Next, s=0, r=8'h03 -> q=8'h0C and changed=8'h03.
- POLICY=0, q=8'h0C, s=r=8'h05 for 1 edge -> q stays 8'h0C, conflict=8'h05, changed=0, err_sticky=1, err_cnt=1.
- Compare policies from q=8'h0C with s=r=8'h05:
  - POLICY=1 -> q=8'h0D
  - POLICY=2 -> q=8'h08
  - POLICY=3 -> q=8'h09, then 8'h0C, then 8'h09 over 3 edges, with err_cnt=3
- CNT_W=2, 5 consecutive conflicting edges -> err_cnt=3 (saturated). Then clr_err=1 with a conflict on the same edge -> err_cnt=1, err_sticky=1. Then clr_err=1 with no conflict -> err_cnt=0, err_sticky=0.
- Enable and reset interactions:
  - en=0 with s=8'hFF, r=0 -> q unchanged and changed=0.
  - rst_n pulled low between clock edges while s=8'hFF and en=1 -> q returns to INIT immediately, with no update on the coincident edge.

Source files
------------

// File: rtl/sr_flop_bank.sv
// sr_flop_bank: bank of clocked SR flip-flops with conflict policy, change/conflict flags and saturating error count
module sr_flop_bank #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] INIT   = '0,
    parameter int               POLICY = 0,
    parameter int               CNT_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic [WIDTH-1:0] r_i,
    input  logic             clr_err_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qb_o,
    output logic [WIDTH-1:0] conflict_o,
    output logic [WIDTH-1:0] changed_o,
    output logic             err_sticky_o,
    output logic [CNT_W-1:0] err_cnt_o
);
    if (POLICY < 0 || POLICY > 3) begin : g_bad_policy
        $error("sr_flop_bank: POLICY must be 0..3");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("sr_flop_bank: WIDTH must be 1..64");
    end
    if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
        $error("sr_flop_bank: CNT_W must be 2..16");
    end
    logic [WIDTH-1:0] q_q, q_d, conflict_q, conflict_d, changed_q, changed_d, both, pol;
    logic             err_q, err_d, any_conflict;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        both         = s_i & r_i;
        pol          = POLICY == 1 ? '1 : POLICY == 2 ? '0 : POLICY == 3 ? ~q_q : q_q;
        // Plain SR on non-conflicting bits; conflicting bits take the policy value.
        q_d          = en_i ? (((q_q | s_i) & ~r_i & ~both) | (both & pol)) : q_q;
        conflict_d   = en_i ? both : '0;
        changed_d    = q_d ^ q_q;
        any_conflict = |conflict_d;
        err_d        = clr_err_i ? any_conflict : (err_q | any_conflict);
        cnt_d        = clr_err_i ? {{(CNT_W-1){1'b0}}, any_conflict}
                     : (any_conflict && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_q        <= INIT;
            conflict_q <= '0;
            changed_q  <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            q_q        <= q_d;
            conflict_q <= conflict_d;
            changed_q  <= changed_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end
    assign q_o          = q_q;
    assign qb_o         = ~q_q;
    assign conflict_o   = conflict_q;
    assign changed_o    = changed_q;
    assign err_sticky_o = err_q;
    assign err_cnt_o    = cnt_q;
endmodule

// File: tb/tb_sr_flop_bank.sv
// tb_sr_flop_bank: four banks (one per policy) driven in parallel and checked against a per-bit behavioural model
module tb_sr_flop_bank;
    logic       clk = 1'b0, rst_n = 1'b1, en = 1'b0, clr = 1'b0;
    logic [7:0] s = '0, r = '0;
    logic [7:0] q_w [4], qb_w [4], cf_w [4], ch_w [4], cnt_w [4];
    logic       st_w [4];
    logic [7:0] mq [4], mcf [4], mch [4];
    logic       mst [4];
    int         mcnt [4];
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int CW = (k == 1) ? 2 : 8;
        logic [CW-1:0] c;
        sr_flop_bank #(.WIDTH(8), .INIT(k == 0 ? 8'hA5 : 8'h00), .POLICY(k), .CNT_W(CW)) u_dut (
            .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .s_i(s), .r_i(r), .clr_err_i(clr),
            .q_o(q_w[k]), .qb_o(qb_w[k]), .conflict_o(cf_w[k]), .changed_o(ch_w[k]),
            .err_sticky_o(st_w[k]), .err_cnt_o(c));
        assign cnt_w[k] = 8'(c);
    end

    function automatic int cmax(input int k);
        return k == 1 ? 3 : 255;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mq[k] = (k == 0) ? 8'hA5 : 8'h00;
            mcf[k] = '0; mch[k] = '0; mst[k] = 1'b0; mcnt[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic [7:0] nq;
        bit anyc;
        for (int k = 0; k < 4; k++) begin
            nq = mq[k];
            anyc = 0;
            for (int i = 0; i < 8; i++) begin
                if (en && s[i] && r[i]) begin
                    anyc = 1;
                    if (k == 1) nq[i] = 1'b1;
                    else if (k == 2) nq[i] = 1'b0;
                    else if (k == 3) nq[i] = ~mq[k][i];
                end else if (en && s[i]) nq[i] = 1'b1;
                else if (en && r[i]) nq[i] = 1'b0;
            end
            mcf[k] = en ? (s & r) : 8'h00;
            mch[k] = nq ^ mq[k];
            mq[k]  = nq;
            if (clr) begin
                mcnt[k] = anyc ? 1 : 0;
                mst[k]  = anyc;
            end else if (anyc) begin
                mst[k]  = 1'b1;
                if (mcnt[k] < cmax(k)) mcnt[k]++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string where);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s.q%0d", where, k), q_w[k], mq[k]);
            chk($sformatf("%s.qb%0d", where, k), qb_w[k], ~mq[k]);
            chk($sformatf("%s.conflict%0d", where, k), cf_w[k], mcf[k]);
            chk($sformatf("%s.changed%0d", where, k), ch_w[k], mch[k]);
            chk($sformatf("%s.sticky%0d", where, k), {7'b0, st_w[k]}, {7'b0, mst[k]});
            chk($sformatf("%s.cnt%0d", where, k), cnt_w[k], 8'(mcnt[k]));
        end
    endtask

    task automatic step(input logic [7:0] sv, input logic [7:0] rv, input logic ev, input logic cv, input string where);
        s = sv; r = rv; en = ev; clr = cv;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_all(where);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk_all("reset");
        chk("reset_q_a5", q_w[0], 8'hA5);
        chk("reset_qb_5a", qb_w[0], 8'h5A);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h0F, 8'h00, 1, 0, "set");
        chk("plan_set_q", q_w[2], 8'h0F);
        chk("plan_set_changed", ch_w[2], 8'h0F);
        step(8'h00, 8'h03, 1, 0, "rst");
        chk("plan_rst_q", q_w[2], 8'h0C);
        chk("plan_rst_changed", ch_w[2], 8'h03);
        step(8'h05, 8'h05, 1, 0, "conf1");
        chk("plan_p1", q_w[1], 8'h0D);
        chk("plan_p2", q_w[2], 8'h08);
        chk("plan_p3", q_w[3], 8'h09);
        chk("plan_conflict", cf_w[0], 8'h05);
        step(8'h05, 8'h05, 1, 0, "conf2");
        chk("plan_p3_b", q_w[3], 8'h0C);
        step(8'h05, 8'h05, 1, 0, "conf3");
        chk("plan_p3_c", q_w[3], 8'h09);
        chk("plan_p3_cnt", cnt_w[3], 8'd3);
        step(8'h05, 8'h05, 1, 0, "conf4");
        step(8'h05, 8'h05, 1, 0, "conf5");
        chk("plan_sat", cnt_w[1], 8'd3);
        step(8'h05, 8'h05, 1, 1, "clr_conf");
        chk("plan_clr_conf", cnt_w[1], 8'd1);
        step(8'h00, 8'h00, 1, 1, "clr");
        chk("plan_clr", cnt_w[1], 8'd0);
        step(8'hFF, 8'h00, 0, 0, "en0");
        chk("plan_en0_changed", ch_w[0], 8'h00);
        for (int n = 0; n < 300; n++)
            step(8'($urandom), 8'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0), "rand");
        s = 8'hFF; r = 8'h00; en = 1'b1; clr = 1'b0;
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk_all("midreset");
        @(posedge clk);
        @(negedge clk);
        chk_all("reset_edge");
        rst_n = 1'b1;
        for (int n = 0; n < 100; n++)
            step(8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), "rand2");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
